// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
// Shares one single-port SRAM (1-cycle read latency) between NUM_PORTS
// requesters using a req/gnt handshake. Grants are issued combinationally
// in the same cycle as the request, and read data comes back with rvalid_o
// one cycle later. With INIT_ZERO != 0, the whole array is zero-filled
// after reset, before any grant is issued.
//
// Configuration macro:
//   SRAM_ARB_RR_EN  defined   -> round-robin arbitration; the search starts at rr_ptr
//                   undefined -> fixed priority; port 0 has the highest priority
module sram_port_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int DATA_WIDTH = 64,
  parameter int NUM_WORDS  = 1024,
  parameter int INIT_ZERO  = 1,
  localparam int AW = $clog2(NUM_WORDS),
  localparam int DW = DATA_WIDTH,
  localparam int BW = (DATA_WIDTH + 7) / 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_PORTS-1:0]    req_i,
  output logic [NUM_PORTS-1:0]    gnt_o,
  input  logic [NUM_PORTS-1:0]    we_i,
  input  logic [NUM_PORTS*AW-1:0] addr_i,
  input  logic [NUM_PORTS*DW-1:0] wdata_i,
  input  logic [NUM_PORTS*BW-1:0] be_i,
  output logic [NUM_PORTS-1:0]    rvalid_o,
  output logic [DW-1:0]           rdata_o,
  output logic                    init_done_o,
  output logic                    sram_req_o,
  output logic                    sram_we_o,
  output logic [AW-1:0]           sram_addr_o,
  output logic [DW-1:0]           sram_wdata_o,
  output logic [BW-1:0]           sram_be_o,
  input  logic [DW-1:0]           sram_rdata_i
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_t;

  localparam state_t        RST_STATE = (INIT_ZERO != 0) ? ST_INIT : ST_IDLE;
  localparam logic          RST_DONE  = (INIT_ZERO != 0) ? 1'b0 : 1'b1;
  localparam logic [AW-1:0] LAST_WORD = AW'(NUM_WORDS - 1);

  state_t        state;
  state_t        state_next;
  logic [AW-1:0] init_cnt;
  logic          grant_valid;
  logic [PW-1:0] grant_idx;
  logic [PW-1:0] search_start;
  logic          do_grant;

  // The SRAM returns data on its own output one cycle after the read; pass it through unqualified
  assign rdata_o  = sram_rdata_i;
  assign do_grant = grant_valid && (state == ST_IDLE);

`ifdef SRAM_ARB_RR_EN
  logic [PW-1:0] rr_ptr;

  assign search_start = rr_ptr;

  // Round-robin pointer: move to the port just after the one granted
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr <= '0;
    end else if (do_grant) begin
      rr_ptr <= (grant_idx == PW'(NUM_PORTS - 1)) ? '0 : grant_idx + PW'(1);
    end else begin
      rr_ptr <= rr_ptr;
    end
  end
`else
  assign search_start = '0;
`endif

  // Pick the first requesting port at or after search_start, wrapping around
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!grant_valid && req_i[(int'(search_start) + i) % NUM_PORTS]) begin
        grant_valid = 1'b1;
        grant_idx   = PW'((int'(search_start) + i) % NUM_PORTS);
      end else begin
        grant_valid = grant_valid;
        grant_idx   = grant_idx;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= RST_STATE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and SRAM/grant drive: INIT sweeps zeros, IDLE forwards the winning port
  always_comb begin
    state_next   = state;
    gnt_o        = '0;
    sram_req_o   = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    sram_be_o    = '0;
    case (state)
      ST_INIT: begin
        sram_req_o  = 1'b1;
        sram_we_o   = 1'b1;
        sram_be_o   = '1;
        sram_addr_o = init_cnt;
        if (init_cnt == LAST_WORD) begin
          state_next = ST_IDLE;
        end else begin
          state_next = ST_INIT;
        end
      end
      ST_IDLE: begin
        state_next = ST_IDLE;
        if (grant_valid) begin
          gnt_o[grant_idx] = 1'b1;
          sram_req_o       = 1'b1;
          sram_we_o        = we_i[grant_idx];
          sram_addr_o      = addr_i[int'(grant_idx)*AW +: AW];
          sram_wdata_o     = wdata_i[int'(grant_idx)*DW +: DW];
          sram_be_o        = be_i[int'(grant_idx)*BW +: BW];
        end else begin
          gnt_o = '0;
        end
      end
      default: begin
        state_next = RST_STATE;
      end
    endcase
  end

  // Zero-fill address counter, advancing once per INIT cycle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      init_cnt <= '0;
    end else if (state == ST_INIT) begin
      init_cnt <= init_cnt + AW'(1);
    end else begin
      init_cnt <= init_cnt;
    end
  end

  // Init-done flag: set as the last word is written, then held until reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      init_done_o <= RST_DONE;
    end else if ((state == ST_INIT) && (init_cnt == LAST_WORD)) begin
      init_done_o <= 1'b1;
    end else begin
      init_done_o <= init_done_o;
    end
  end

  // Read return: flag the granted reader one cycle after its grant; writes return nothing
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_o <= '0;
    end else if (do_grant && !we_i[grant_idx]) begin
      rvalid_o <= gnt_o;
    end else begin
      rvalid_o <= '0;
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter (2 ports, 64-bit data, 16 words, zero-fill on).
// It contains a behavioural SRAM, a directed vector table, reset and init sequences,
// and a randomized phase checked against a shadow-memory reference model.
module tb_sram_port_arbiter;
  localparam int NP = 2;
  localparam int DW = 64;
  localparam int NW = 16;
  localparam int AW = 4;
  localparam int BW = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NP-1:0]     req;
  logic [NP-1:0]     gnt;
  logic [NP-1:0]     we;
  logic [NP*AW-1:0]  addr;
  logic [NP*DW-1:0]  wdata;
  logic [NP*BW-1:0]  be;
  logic [NP-1:0]     rvalid;
  logic [DW-1:0]     rdata;
  logic              init_done;
  logic              sram_req;
  logic              sram_we;
  logic [AW-1:0]     sram_addr;
  logic [DW-1:0]     sram_wdata;
  logic [BW-1:0]     sram_be;
  logic [DW-1:0]     sram_rdata = '0;

  int n_cmp = 0;
  int n_bad = 0;

  sram_port_arbiter #(
    .NUM_PORTS(NP), .DATA_WIDTH(DW), .NUM_WORDS(NW), .INIT_ZERO(1)
  ) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt), .we_i(we),
    .addr_i(addr), .wdata_i(wdata), .be_i(be), .rvalid_o(rvalid),
    .rdata_o(rdata), .init_done_o(init_done), .sram_req_o(sram_req),
    .sram_we_o(sram_we), .sram_addr_o(sram_addr), .sram_wdata_o(sram_wdata),
    .sram_be_o(sram_be), .sram_rdata_i(sram_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] merge(input logic [63:0] old_w, input logic [63:0] new_w,
                                        input logic [7:0] mask);
    logic [63:0] r;
    r = old_w;
    for (int b = 0; b < 8; b++) begin
      if (mask[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    end
    return r;
  endfunction

  // Behavioural single-port SRAM with a one-cycle read latency
  logic [63:0] mem [NW];
  always @(posedge clk) begin
    if (sram_req) begin
      if (sram_we) mem[sram_addr] <= merge(mem[sram_addr], sram_wdata, sram_be);
      else         sram_rdata     <= mem[sram_addr];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] r, input logic [1:0] w,
                       input logic [3:0] a0, input logic [3:0] a1,
                       input logic [63:0] d0, input logic [63:0] d1,
                       input logic [7:0] b0, input logic [7:0] b1);
    req = r; we = w; addr = {a1, a0}; wdata = {d1, d0}; be = {b1, b0};
  endtask

  // Entered at the negedge right after reset is released
  task automatic run_init();
    drive(2'b10, 2'b00, 4'd0, 4'd0, 64'd0, 64'd0, 8'h00, 8'h00);
    for (int k = 0; k < NW; k++) begin
      #1;
      chk("init_req", sram_req, 1);
      chk("init_we", sram_we, 1);
      chk("init_addr", sram_addr, 64'(k));
      chk("init_wdata", sram_wdata, 0);
      chk("init_be", sram_be, 64'hFF);
      chk("init_gnt_held", gnt, 0);
      chk("init_done_low", init_done, 0);
      @(posedge clk);
      @(negedge clk);
    end
    #1;
    chk("init_done_high", init_done, 1);
    chk("init_first_gnt", gnt, 2'b10);
    chk("init_first_we", sram_we, 0);
    @(posedge clk); #1;
    chk("init_first_rvalid", rvalid, 2'b10);
    chk("init_first_rdata", rdata, 0);
    @(negedge clk);
    drive(2'b00, 2'b00, 4'd0, 4'd0, 64'd0, 64'd0, 8'h00, 8'h00);
  endtask

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  we;
    logic [3:0]  a0;
    logic [3:0]  a1;
    logic [63:0] d0;
    logic [63:0] d1;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [1:0]  exp_gnt;
    logic [1:0]  exp_rv;
    logic [63:0] exp_rd;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] r, input logic [1:0] w,
                              input logic [3:0] a0, input logic [3:0] a1,
                              input logic [63:0] d0, input logic [7:0] b0,
                              input logic [1:0] eg, input logic [1:0] erv,
                              input logic [63:0] erd);
    vec_t v;
    v.req = r; v.we = w; v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = 64'd0;
    v.b0 = b0; v.b1 = 8'h00; v.exp_gnt = eg; v.exp_rv = erv; v.exp_rd = erd;
    return v;
  endfunction

  function automatic int pick(input logic [1:0] r, input int start);
    for (int k = 0; k < NP; k++) begin
      if (r[(start + k) % NP]) return (start + k) % NP;
    end
    return -1;
  endfunction

  vec_t        tbl [10];
  logic [63:0] shadow [NW];
  logic [1:0]  pend;
  logic [1:0]  op_we;
  logic [3:0]  op_a [NP];
  logic [63:0] op_d [NP];
  logic [7:0]  op_b [NP];
  logic [1:0]  eg;
  logic [1:0]  erv;
  logic [63:0] erd;
  int          ptr;
  int          base;
  int          g;

  initial begin
    tbl[0] = mk(2'b01, 2'b01, 4'd5, 4'd0, 64'h0000_0000_DEAD_BEEF, 8'hFF, 2'b01, 2'b00, 64'd0);
    tbl[1] = mk(2'b10, 2'b00, 4'd0, 4'd5, 64'd0, 8'h00, 2'b10, 2'b10, 64'h0000_0000_DEAD_BEEF);
    tbl[2] = mk(2'b01, 2'b01, 4'd3, 4'd0, 64'h1111_2222_3333_4444, 8'h0F, 2'b01, 2'b00, 64'd0);
    tbl[3] = mk(2'b01, 2'b00, 4'd3, 4'd0, 64'd0, 8'h00, 2'b01, 2'b01, 64'h0000_0000_3333_4444);
`ifdef SRAM_ARB_RR_EN
    tbl[4] = mk(2'b11, 2'b00, 4'd5, 4'd3, 64'd0, 8'h00, 2'b10, 2'b10, 64'h0000_0000_3333_4444);
    tbl[5] = mk(2'b11, 2'b00, 4'd5, 4'd3, 64'd0, 8'h00, 2'b01, 2'b01, 64'h0000_0000_DEAD_BEEF);
    tbl[6] = mk(2'b11, 2'b00, 4'd5, 4'd3, 64'd0, 8'h00, 2'b10, 2'b10, 64'h0000_0000_3333_4444);
    tbl[7] = mk(2'b11, 2'b00, 4'd5, 4'd3, 64'd0, 8'h00, 2'b01, 2'b01, 64'h0000_0000_DEAD_BEEF);
`else
    tbl[4] = mk(2'b11, 2'b00, 4'd5, 4'd3, 64'd0, 8'h00, 2'b01, 2'b01, 64'h0000_0000_DEAD_BEEF);
    tbl[5] = mk(2'b11, 2'b00, 4'd5, 4'd3, 64'd0, 8'h00, 2'b01, 2'b01, 64'h0000_0000_DEAD_BEEF);
    tbl[6] = mk(2'b11, 2'b00, 4'd5, 4'd3, 64'd0, 8'h00, 2'b01, 2'b01, 64'h0000_0000_DEAD_BEEF);
    tbl[7] = mk(2'b11, 2'b00, 4'd5, 4'd3, 64'd0, 8'h00, 2'b01, 2'b01, 64'h0000_0000_DEAD_BEEF);
`endif
    tbl[8] = mk(2'b10, 2'b00, 4'd5, 4'd3, 64'd0, 8'h00, 2'b10, 2'b10, 64'h0000_0000_3333_4444);
    tbl[9] = mk(2'b00, 2'b00, 4'd0, 4'd0, 64'd0, 8'h00, 2'b00, 2'b00, 64'd0);

    // Reset state, then the zero-fill sweep with requests held off
    drive(2'b00, 2'b00, 4'd0, 4'd0, 64'd0, 64'd0, 8'h00, 8'h00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_gnt", gnt, 0);
    rst = 1'b0;
    run_init();

    // Directed vector table: write/read-back, partial write, arbitration order
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].req, tbl[i].we, tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1,
            tbl[i].b0, tbl[i].b1);
      #1;
      chk($sformatf("tbl%0d_gnt", i), gnt, tbl[i].exp_gnt);
      if (tbl[i].exp_gnt != 2'b00) begin
        chk($sformatf("tbl%0d_addr", i), sram_addr, tbl[i].exp_gnt[1] ? tbl[i].a1 : tbl[i].a0);
        chk($sformatf("tbl%0d_we", i), sram_we, tbl[i].exp_gnt[1] ? tbl[i].we[1] : tbl[i].we[0]);
      end else begin
        chk($sformatf("tbl%0d_idle_req", i), sram_req, 0);
      end
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_rvalid", i), rvalid, tbl[i].exp_rv);
      if (tbl[i].exp_rv != 2'b00) chk($sformatf("tbl%0d_rdata", i), rdata, tbl[i].exp_rd);
      @(negedge clk);
    end

    // Reset right after a read grant: the pending rvalid is dropped and INIT restarts at word 0
    drive(2'b01, 2'b00, 4'd5, 4'd0, 64'd0, 64'd0, 8'h00, 8'h00);
    #1;
    chk("midrst_gnt", gnt, 2'b01);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_rvalid", rvalid, 0);
    chk("midrst_init_done", init_done, 0);
    chk("midrst_addr", sram_addr, 0);
    chk("midrst_we", sram_we, 1);
    chk("midrst_gnt_off", gnt, 0);
    @(negedge clk);
    rst = 1'b0;
    run_init();

    // Randomized traffic against a shadow-memory model
    for (int w = 0; w < NW; w++) shadow[w] = 64'd0;
    ptr = 0;
    pend = 2'b00;
    op_we = 2'b00;
    for (int p = 0; p < NP; p++) begin
      op_a[p] = 4'd0; op_d[p] = 64'd0; op_b[p] = 8'h00;
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int p = 0; p < NP; p++) begin
        if (!pend[p] && ($urandom_range(3) != 0)) begin
          pend[p]  = 1'b1;
          op_we[p] = 1'($urandom_range(1));
          op_a[p]  = 4'($urandom_range(NW - 1));
          op_d[p]  = {$urandom(), $urandom()};
          op_b[p]  = 8'($urandom_range(255));
        end
      end
      drive(pend, op_we, op_a[0], op_a[1], op_d[0], op_d[1], op_b[0], op_b[1]);
      #1;
`ifdef SRAM_ARB_RR_EN
      base = ptr;
`else
      base = 0;
`endif
      g = pick(pend, base);
      erv = 2'b00;
      erd = 64'd0;
      if (g < 0) begin
        chk("rnd_gnt_none", gnt, 0);
        chk("rnd_idle_req", sram_req, 0);
      end else begin
        eg = 2'b00;
        eg[g] = 1'b1;
        chk("rnd_gnt", gnt, eg);
        chk("rnd_req", sram_req, 1);
        chk("rnd_addr", sram_addr, op_a[g]);
        chk("rnd_we", sram_we, op_we[g]);
        if (op_we[g]) begin
          chk("rnd_wdata", sram_wdata, op_d[g]);
          chk("rnd_be", sram_be, op_b[g]);
          shadow[op_a[g]] = merge(shadow[op_a[g]], op_d[g], op_b[g]);
        end else begin
          erv = eg;
          erd = shadow[op_a[g]];
        end
        ptr = (g + 1) % NP;
        pend[g] = 1'b0;
      end
      @(posedge clk); #1;
      chk("rnd_rvalid", rvalid, erv);
      if (erv != 2'b00) chk("rnd_rdata", rdata, erd);
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
